// File: rtl/flex_counter_ud_pkg.sv
// Shared types and default sizes for the up/down flexible counter.
package flex_counter_pkg;

  // Default width of count_out, load_val and rollover_val.
  localparam int NUM_BITS_DEF  = 4;
  // Default width of the saturating wrap-event counter.
  localparam int WRAP_BITS_DEF = 8;

  // Counting direction, taken straight from the count_down pin.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Limit behaviour, taken straight from the saturate pin.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_t;

endpackage : flex_counter_pkg

// File: rtl/flex_counter_ud_next.sv
// Next-count function for one enabled counting step over the range 1..R.
// Purely combinational; the caller decides whether the step is taken.
module flex_counter_next
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic [NUM_BITS-1:0] count,
  input  logic [NUM_BITS-1:0] rollover_val,
  input  dir_t                dir,
  input  mode_t               mode,
  output logic [NUM_BITS-1:0] next_count,
  output logic                wrap_event
);

  localparam logic [NUM_BITS-1:0] COUNT_ZERO = '0;
  localparam logic [NUM_BITS-1:0] COUNT_ONE  = NUM_BITS'(1);

  // Step the count toward/around the limits; increment only happens below R,
  // so the +1 can never overflow NUM_BITS.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    next_count = count;
    wrap_event = 1'b0;
    if (rollover_val == COUNT_ZERO) begin
      next_count = count;
    end else if (dir == DIR_UP) begin
      if (count < rollover_val) begin
        next_count = count + COUNT_ONE;
      end else if (mode == MODE_WRAP) begin
        next_count = COUNT_ONE;
        wrap_event = 1'b1;
      end else begin
        next_count = rollover_val;
      end
    end else begin
      if (count > rollover_val) begin
        // Above the range: re-enter at the top without a wrap.
        next_count = rollover_val;
      end else if (count > COUNT_ONE) begin
        next_count = count - COUNT_ONE;
      end else if (mode == MODE_WRAP) begin
        next_count = rollover_val;
        wrap_event = 1'b1;
      end else begin
        next_count = COUNT_ONE;
      end
    end
  end

endmodule : flex_counter_next

// File: rtl/flex_counter_ud.sv
// Generic up/down count primitive with parallel load, wrap/saturate mode,
// registered range flags, a wrap-event pulse and a saturating wrap counter.
// All outputs come straight from flops.
module flex_counter_ud
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS  = NUM_BITS_DEF,
  parameter int WRAP_BITS = WRAP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 count_enable,
  input  logic                 count_down,
  input  logic                 load,
  input  logic [NUM_BITS-1:0]  load_val,
  input  logic                 saturate,
  input  logic [NUM_BITS-1:0]  rollover_val,
  output logic [NUM_BITS-1:0]  count_out,
  output logic                 rollover_flag,
  output logic                 underflow_flag,
  output logic                 wrap_pulse,
  output logic [WRAP_BITS-1:0] wrap_count
);

  localparam logic [NUM_BITS-1:0]  COUNT_ZERO = '0;
  localparam logic [NUM_BITS-1:0]  COUNT_ONE  = NUM_BITS'(1);
  localparam logic [WRAP_BITS-1:0] WRAP_ONE   = WRAP_BITS'(1);
  localparam logic [WRAP_BITS-1:0] WRAP_MAX   = '1;

  logic [NUM_BITS-1:0]  count_q, count_d;
  logic                 rollover_q, rollover_d;
  logic                 underflow_q, underflow_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_BITS-1:0] wrap_count_q, wrap_count_d;

  logic [NUM_BITS-1:0]  step_count;
  logic                 step_wrap;
  logic                 range_valid;

  assign range_valid = (rollover_val != COUNT_ZERO);

  flex_counter_next #(
    .NUM_BITS (NUM_BITS)
  ) u_next (
    .count        (count_q),
    .rollover_val (rollover_val),
    .dir          (dir_t'(count_down)),
    .mode         (mode_t'(saturate)),
    .next_count   (step_count),
    .wrap_event   (step_wrap)
  );

  // Priority clear > load > count_enable > hold; flags track the value being
  // written so they line up with count_out in the same cycle.
  always_comb begin
    count_d      = count_q;
    rollover_d   = rollover_q;
    underflow_d  = underflow_q;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;
    if (clear) begin
      count_d      = COUNT_ZERO;
      rollover_d   = 1'b0;
      underflow_d  = 1'b0;
      wrap_count_d = '0;
    end else if (load) begin
      count_d     = load_val;
      rollover_d  = range_valid && (load_val == rollover_val);
      underflow_d = range_valid && (load_val == COUNT_ONE);
    end else if (count_enable) begin
      count_d     = step_count;
      rollover_d  = range_valid && (step_count == rollover_val);
      underflow_d = range_valid && (step_count == COUNT_ONE);
      if (step_wrap) begin
        wrap_pulse_d = 1'b1;
        if (wrap_count_q != WRAP_MAX) begin
          wrap_count_d = wrap_count_q + WRAP_ONE;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count_q      <= COUNT_ZERO;
      rollover_q   <= 1'b0;
      underflow_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      count_q      <= count_d;
      rollover_q   <= rollover_d;
      underflow_q  <= underflow_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = rollover_q;
  assign underflow_flag = underflow_q;
  assign wrap_pulse     = wrap_pulse_q;
  assign wrap_count     = wrap_count_q;

endmodule : flex_counter_ud

// File: tb/tb_flex_counter_ud.sv
// Directed bench for flex_counter_ud: hand sequences for reset, the long up
// wrap and wrap_count saturation, plus a table of single-cycle vectors.
module tb_flex_counter_ud;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       count_enable = 1'b0;
  logic       count_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       saturate = 1'b0;
  logic [3:0] rollover_val = '0;

  logic [3:0] count_out, count_out_s;
  logic       rollover_flag, rollover_flag_s;
  logic       underflow_flag, underflow_flag_s;
  logic       wrap_pulse, wrap_pulse_s;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flex_counter_ud #(.NUM_BITS(4), .WRAP_BITS(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .load(load), .load_val(load_val),
    .saturate(saturate), .rollover_val(rollover_val),
    .count_out(count_out), .rollover_flag(rollover_flag),
    .underflow_flag(underflow_flag), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count)
  );

  // Narrow wrap counter instance, sharing stimulus, for the saturation case.
  flex_counter_ud #(.NUM_BITS(4), .WRAP_BITS(2)) dut_small (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .count_down(count_down), .load(load), .load_val(load_val),
    .saturate(saturate), .rollover_val(rollover_val),
    .count_out(count_out_s), .rollover_flag(rollover_flag_s),
    .underflow_flag(underflow_flag_s), .wrap_pulse(wrap_pulse_s),
    .wrap_count(wrap_count_s)
  );

  typedef struct {
    logic       clr, ld, ce, dn, sat;
    logic [3:0] lv, r;
    logic [3:0] e_cnt;
    logic       e_ro, e_un, e_wp;
    logic [7:0] e_wc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int ec, input int ero,
                           input int eun, input int ewp, input int ewc);
    check({tag, " count_out"},      int'(count_out),      ec);
    check({tag, " rollover_flag"},  int'(rollover_flag),  ero);
    check({tag, " underflow_flag"}, int'(underflow_flag), eun);
    check({tag, " wrap_pulse"},     int'(wrap_pulse),     ewp);
    check({tag, " wrap_count"},     int'(wrap_count),     ewc);
  endtask

  task automatic drive(input logic clr, ld, ce, dn, sat,
                       input logic [3:0] lv, r);
    clear = clr; load = ld; count_enable = ce; count_down = dn;
    saturate = sat; load_val = lv; rollover_val = r;
  endtask

  // Advance one edge and settle away from it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic clr, ld, ce, dn, sat,
                              input logic [3:0] lv, r, ec,
                              input logic ero, eun, ewp,
                              input logic [7:0] ewc);
    vec_t v;
    v.clr = clr; v.ld = ld; v.ce = ce; v.dn = dn; v.sat = sat;
    v.lv = lv; v.r = r; v.e_cnt = ec;
    v.e_ro = ero; v.e_un = eun; v.e_wp = ewp; v.e_wc = ewc;
    vecs.push_back(v);
  endfunction

  initial begin
    //  clr ld ce dn sat lv  r   cnt ro un wp wc
    // Down in saturate mode from a loaded 3, then switch to wrap.
    add(0, 1, 0, 1, 1, 3,  9,  3, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0,  9,  2, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0,  9,  1, 0, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0,  9,  1, 0, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0,  9,  1, 0, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0,  9,  1, 0, 1, 0, 1);
    add(0, 0, 1, 1, 0, 0,  9,  9, 1, 0, 1, 2);
    // Priority: clear beats load, load beats count_enable.
    add(1, 1, 1, 0, 0, 5,  9,  0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 5,  9,  5, 0, 0, 0, 0);
    // Above-range value: up wraps to 1, down re-enters at R without wrap.
    add(0, 1, 0, 0, 0, 14, 9, 14, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  9,  1, 0, 1, 1, 1);
    add(0, 1, 0, 0, 0, 14, 9, 14, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0,  9,  9, 1, 0, 0, 1);
    // R == 0: count holds, flags drop.
    add(0, 0, 1, 0, 0, 0,  0,  9, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0,  0,  9, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0,  0,  9, 0, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0,  0,  9, 0, 0, 0, 1);
    // Down from 0 goes straight to R with a wrap.
    add(1, 0, 0, 0, 0, 0,  7,  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  7,  7, 1, 0, 1, 1);
    // R == 1 raises both flags; flags hold with count_enable low.
    add(0, 1, 0, 0, 0, 1,  1,  1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  5,  1, 1, 1, 0, 1);
    // Saturate at the top, then wrap from the top.
    add(0, 1, 0, 0, 1, 5,  5,  5, 1, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0,  5,  5, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0,  5,  1, 0, 1, 1, 2);

    // Reset held for two edges with counting requested.
    drive(0, 0, 1, 0, 0, 0, 15);
    rst = 1'b1;
    tick;
    check_all("reset1", 0, 0, 0, 0, 0);
    tick;
    check_all("reset2", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    count_enable = 1'b0;
    tick;
    check_all("post_reset", 0, 0, 0, 0, 0);

    // Up count to R=11 then wrap to 1.
    drive(0, 0, 1, 0, 0, 0, 11);
    for (int i = 1; i <= 11; i++) begin
      tick;
      check_all($sformatf("up_step%0d", i), i, (i == 11) ? 1 : 0,
                (i == 1) ? 1 : 0, 0, 0);
    end
    tick;
    check_all("up_wrap", 1, 0, 1, 1, 1);
    tick;
    check_all("up_after_wrap", 2, 0, 0, 0, 1);

    // Table vectors.
    foreach (vecs[k]) begin
      drive(vecs[k].clr, vecs[k].ld, vecs[k].ce, vecs[k].dn, vecs[k].sat,
            vecs[k].lv, vecs[k].r);
      tick;
      check_all($sformatf("vec%0d", k), int'(vecs[k].e_cnt), int'(vecs[k].e_ro),
                int'(vecs[k].e_un), int'(vecs[k].e_wp), int'(vecs[k].e_wc));
    end

    // wrap_count saturation on the 2-bit instance, R=1 wrapping every cycle.
    drive(1, 0, 0, 0, 0, 0, 1);
    tick;
    check("sat_clear wrap_count_s", int'(wrap_count_s), 0);
    drive(0, 0, 1, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      tick;
      check($sformatf("sat%0d count_out_s", i), int'(count_out_s), 1);
      check($sformatf("sat%0d wrap_pulse_s", i), int'(wrap_pulse_s),
            (i >= 2) ? 1 : 0);
      check($sformatf("sat%0d wrap_count_s", i), int'(wrap_count_s),
            (i - 1 > 3) ? 3 : i - 1);
      check($sformatf("sat%0d wrap_count", i), int'(wrap_count), i - 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick;
    check("sat_idle wrap_pulse_s", int'(wrap_pulse_s), 0);
    check("sat_idle wrap_count_s", int'(wrap_count_s), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_flex_counter_ud
